cpu6_mux_port: RTL and testbench

Memory-mapped serial port that answers CPU6 bus cycles: the bus responder sitting on the far end of the CPU6 address, data and write-enable lines. Decodes a two-byte register window and queues CPU writes into a TX FIFO drained by an 8N1 serializer. Returns status and received bytes on the CPU read-data bus. Optionally deserializes an RX line.

---
 rtl/cpu6_mux_port.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_cpu6_mux_port.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu6_mux_port.sv
// CPU6 bus responder: two-byte STATUS/DATA window, TX FIFO feeding an 8N1 serializer.
// Optional RX deserializer and its flags are compiled in when CPU6_MUX_RX_EN is defined.
module cpu6_mux_port #(
    parameter logic [15:0] BASE_ADDR    = 16'hF200,
    parameter logic [15:0] CLKS_PER_BIT = 16'd434,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] addressBus,
    input  logic        writeEnBus,
    input  logic [7:0]  dataOutBus,
    output logic [7:0]  dataInBus,
    output logic        select,
    output logic        tx,
    input  logic        rx
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] BIT_LAST   = CLKS_PER_BIT - 16'd1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    logic          hit;
    logic          we_q;
    logic          wr_stb;
    logic          data_wr;
    logic          stat_wr;
    logic          push;
    logic          tx_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;

    tx_state_e     tx_state_q;
    logic [15:0]   tx_baud_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_shift_q;
    logic          tx_q;
    logic          tx_bit_d;
    logic          tx_baud_end;
    logic          tx_overflow_q;
    logic          tx_idle;

    logic          rx_ready;
    logic          rx_framing_err;
    logic          rx_overrun;
    logic [7:0]    rx_data;
    logic [7:0]    status_d;
    logic [7:0]    rdata_d;
    logic [7:0]    rdata_q;
    logic          select_q;

    assign hit        = addressBus[15:1] == BASE_ADDR[15:1];
    // A strobe held high for several cycles must only write once.
    assign wr_stb     = writeEnBus & ~we_q & hit;
    assign data_wr    = wr_stb & addressBus[0];
    assign stat_wr    = wr_stb & ~addressBus[0];
    assign fifo_full  = count_q == FULL_COUNT;
    assign fifo_empty = count_q == '0;
    assign push       = data_wr & ~fifo_full;

    assign tx_baud_end = tx_baud_q == BIT_LAST;
    assign tx_pop      = ~fifo_empty & ((tx_state_q == TX_IDLE) |
                                        ((tx_state_q == TX_STOP) & tx_baud_end));
    assign tx_idle     = fifo_empty & (tx_state_q == TX_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            we_q <= 1'b0;
        end else begin
            we_q <= writeEnBus;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= dataOutBus;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !tx_pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && tx_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (tx_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        tx_bit_d = 1'b1;
        unique case (tx_state_q)
            TX_START: tx_bit_d = 1'b0;
            TX_DATA:  tx_bit_d = tx_shift_q[0];
            default:  tx_bit_d = 1'b1;
        endcase
    end

    // tx is the state-derived bit delayed one clock, which gives the two-clock
    // write-to-start latency while keeping every bit exactly CLKS_PER_BIT long.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_q <= tx_bit_d;
            unique case (tx_state_q)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_shift_q <= fifo_mem[rd_ptr_q];
                        tx_baud_q  <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_baud_end) begin
                        tx_baud_q  <= '0;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_baud_q <= tx_baud_q + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_baud_end) begin
                        tx_baud_q  <= '0;
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_bit_q   <= tx_bit_q + 3'd1;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= TX_STOP;
                        end
                    end else begin
                        tx_baud_q <= tx_baud_q + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_baud_end) begin
                        tx_baud_q <= '0;
                        if (tx_pop) begin
                            tx_shift_q <= fifo_mem[rd_ptr_q];
                            tx_state_q <= TX_START;
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end else begin
                        tx_baud_q <= tx_baud_q + 16'd1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_overflow_q <= 1'b0;
        end else begin
            tx_overflow_q <= (data_wr & fifo_full) |
                             (tx_overflow_q & ~(stat_wr & dataOutBus[2]));
        end
    end

`ifdef CPU6_MUX_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    localparam logic [15:0] HALF_LAST = (CLKS_PER_BIT >> 1) - 16'd1;

    rx_state_e   rx_state_q;
    logic        rx_s1_q;
    logic        rx_s2_q;
    logic        rx_s3_q;
    logic [15:0] rx_baud_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic [7:0]  rx_data_q;
    logic        rx_ready_q;
    logic        rx_overrun_q;
    logic        rx_ferr_q;
    logic        rx_stop_end;
    logic        rx_good;
    logic        rx_bad;

    assign rx_stop_end = (rx_state_q == RX_STOP) && (rx_baud_q == BIT_LAST);
    assign rx_good     = rx_stop_end & rx_s2_q;
    assign rx_bad      = rx_stop_end & ~rx_s2_q;

    // Hardware sets take priority over a same-cycle write-one-to-clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_s3_q      <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_baud_q    <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_ready_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            rx_ferr_q    <= 1'b0;
        end else begin
            rx_s1_q      <= rx;
            rx_s2_q      <= rx_s1_q;
            rx_s3_q      <= rx_s2_q;
            rx_ready_q   <= rx_good | (rx_ready_q & ~(stat_wr & dataOutBus[0]));
            rx_overrun_q <= (rx_good & rx_ready_q) |
                            (rx_overrun_q & ~(stat_wr & dataOutBus[4]));
            rx_ferr_q    <= rx_bad | (rx_ferr_q & ~(stat_wr & dataOutBus[3]));
            if (rx_good) begin
                rx_data_q <= rx_shift_q;
            end
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (rx_s3_q && !rx_s2_q) begin
                        rx_baud_q  <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_baud_q == HALF_LAST) begin
                        rx_baud_q  <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_baud_q <= rx_baud_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_baud_q == BIT_LAST) begin
                        rx_baud_q  <= '0;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end
                    end else begin
                        rx_baud_q <= rx_baud_q + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_stop_end) begin
                        rx_baud_q  <= '0;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_baud_q <= rx_baud_q + 16'd1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_ready       = rx_ready_q;
    assign rx_framing_err = rx_ferr_q;
    assign rx_overrun     = rx_overrun_q;
    assign rx_data        = rx_data_q;
`else
    logic unused_rx;

    assign unused_rx      = rx;
    assign rx_ready       = 1'b0;
    assign rx_framing_err = 1'b0;
    assign rx_overrun     = 1'b0;
    assign rx_data        = 8'h00;
`endif

    always_comb begin
        status_d = {2'b00, tx_idle, rx_overrun, rx_framing_err,
                    tx_overflow_q, ~fifo_full, rx_ready};
        rdata_d  = 8'h00;
        if (hit) begin
            rdata_d = addressBus[0] ? rx_data : status_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            select_q <= 1'b0;
            rdata_q  <= 8'h00;
        end else begin
            select_q <= hit;
            rdata_q  <= rdata_d;
        end
    end

    assign select    = select_q;
    assign dataInBus = rdata_q;
    assign tx        = tx_q;

endmodule

// File: tb/tb_cpu6_mux_port.sv
// Bench for cpu6_mux_port: expected TX bytes are queued at write time and compared
// against frames decoded from tx; register reads are checked one cycle after the address.
module tb_cpu6_mux_port;

    localparam logic [15:0] BASE = 16'hF200;
    localparam int          CPB  = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] addressBus = 16'h0000;
    logic        writeEnBus = 1'b0;
    logic [7:0]  dataOutBus = 8'h00;
    logic [7:0]  dataInBus;
    logic        select;
    logic        tx;
    logic        rx = 1'b1;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_cyc = 0;
    int          frames = 0;
    logic [7:0]  exp_q[$];
    int          starts[$];

    cpu6_mux_port #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (16'(CPB)),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .addressBus (addressBus),
        .writeEnBus (writeEnBus),
        .dataOutBus (dataOutBus),
        .dataInBus  (dataInBus),
        .select     (select),
        .tx         (tx),
        .rx         (rx)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_read(input logic [15:0] a, input logic s_exp, input logic [7:0] d_exp,
                            input string tag);
        @(negedge clock);
        addressBus = a;
        writeEnBus = 1'b0;
        @(negedge clock);
        $display("rd  %s addr=%h sel=%b data=%h", tag, a, select, dataInBus);
        check({tag, "_sel"}, 32'(select), 32'(s_exp));
        check({tag, "_data"}, 32'(dataInBus), 32'(d_exp));
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int hold);
        @(negedge clock);
        addressBus = a;
        dataOutBus = d;
        writeEnBus = 1'b1;
        @(posedge clock);
        #1 wr_cyc = cyc;
        repeat (hold - 1) @(posedge clock);
        @(negedge clock);
        writeEnBus = 1'b0;
        $display("wr  addr=%h data=%h hold=%0d", a, d, hold);
    endtask

    task automatic wait_tx_done(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clock);
            addressBus = BASE;
            @(negedge clock);
            if (dataInBus[5]) done = 1'b1;
        end
        check("tx_done_timeout", 32'(done), 32'd1);
        repeat (CPB + 4) @(negedge clock);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            rx = f[k];
            repeat (CPB - 1) @(negedge clock);
        end
        @(negedge clock);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clock);
    endtask

    // Frame monitor: samples each bit at its first and last clock.
    initial begin : monitor
        logic [9:0] first_s;
        logic [9:0] last_s;
        logic [9:0] ef;
        logic [7:0] e;
        bit         aborted;
        int         s;
        forever begin
            @(negedge clock);
            if (reset_n && tx == 1'b0) begin
                s       = cyc;
                aborted = 1'b0;
                first_s = '0;
                last_s  = '0;
                for (int k = 0; k < 10; k++) begin
                    for (int j = 0; j < CPB; j++) begin
                        if (k != 0 || j != 0) @(negedge clock);
                        if (!reset_n) aborted = 1'b1;
                        if (j == 0) first_s[k] = tx;
                        if (j == CPB - 1) last_s[k] = tx;
                    end
                end
                if (!aborted) begin
                    frames++;
                    starts.push_back(s);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'(first_s), 32'h3ff);
                    end else begin
                        e  = exp_q.pop_front();
                        ef = {1'b1, e, 1'b0};
                        $display("frm start=%0d bits=%b expected=%b", s, first_s, ef);
                        check("frame_bits", 32'(first_s), 32'(ef));
                        check("frame_bitlen", 32'(last_s), 32'(ef));
                    end
                end
            end
        end
    end

    initial begin : main
        logic [7:0] burst [5];
        int         w0;
        burst[0] = 8'h01; burst[1] = 8'h80; burst[2] = 8'h55;
        burst[3] = 8'hFF; burst[4] = 8'h3C;

        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_sel", 32'(select), 32'd0);
        check("rst_data", 32'(dataInBus), 32'd0);
        reset_n = 1'b1;

        bus_read(BASE, 1'b1, 8'h22, "status_reset");
        bus_read(BASE + 16'd2, 1'b0, 8'h00, "miss_hi");
        bus_read(BASE - 16'd1, 1'b0, 8'h00, "miss_lo");
        bus_read(BASE + 16'd1, 1'b1, 8'h00, "data_reset");

        // Single byte with a three-cycle strobe.
        frames = 0;
        starts.delete();
        exp_q.push_back(8'hA5);
        bus_write(BASE + 16'd1, 8'hA5, 3);
        w0 = wr_cyc;
        bus_read(BASE, 1'b1, 8'h02, "status_busy");
        wait_tx_done(400);
        check("a5_frames", 32'(frames), 32'd1);
        check("a5_latency", 32'(starts.size() > 0 ? starts[0] : -1), 32'(w0 + 2));

        // Burst of five fills the FIFO, two more overflow.
        frames = 0;
        starts.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(burst[i]);
            bus_write(BASE + 16'd1, burst[i], 1);
        end
        bus_read(BASE, 1'b1, 8'h00, "status_full");
        bus_write(BASE + 16'd1, 8'hEE, 1);
        bus_write(BASE + 16'd1, 8'hDD, 1);
        bus_read(BASE, 1'b1, 8'h04, "status_ovf");
        bus_write(BASE, 8'h04, 1);
        bus_read(BASE, 1'b1, 8'h00, "status_ovf_clr");
        wait_tx_done(1500);
        check("burst_frames", 32'(frames), 32'd5);
        for (int i = 1; i < 5; i++) begin
            if (i < starts.size()) begin
                check("burst_gap", 32'(starts[i] - starts[i-1]), 32'(10 * CPB));
            end
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        bus_write(BASE, 8'hFF, 1);
        bus_read(BASE, 1'b1, 8'h22, "w1c_ignore");

`ifdef CPU6_MUX_RX_EN
        send_rx(8'h3C, 1'b1);
        bus_read(BASE, 1'b1, 8'h23, "rx_status");
        bus_read(BASE + 16'd1, 1'b1, 8'h3C, "rx_data");
        send_rx(8'hC3, 1'b1);
        bus_read(BASE, 1'b1, 8'h33, "rx_ovr_status");
        bus_read(BASE + 16'd1, 1'b1, 8'hC3, "rx_ovr_data");
        bus_write(BASE, 8'h1D, 1);
        bus_read(BASE, 1'b1, 8'h22, "rx_clr");
        send_rx(8'h5A, 1'b0);
        bus_read(BASE, 1'b1, 8'h2A, "rx_ferr");
        bus_read(BASE + 16'd1, 1'b1, 8'hC3, "rx_ferr_data");
        bus_write(BASE, 8'h08, 1);
        @(negedge clock);
        rx = 1'b0;
        repeat ((CPB * 3) / 10) @(negedge clock);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        bus_read(BASE, 1'b1, 8'h22, "rx_glitch");
`else
        send_rx(8'h3C, 1'b1);
        bus_read(BASE, 1'b1, 8'h22, "norx_status");
        bus_read(BASE + 16'd1, 1'b1, 8'h00, "norx_data");
`endif

        // Reset in the middle of a frame.
        exp_q.push_back(8'h00);
        bus_write(BASE + 16'd1, 8'h00, 1);
        repeat (3 * CPB) @(negedge clock);
        check("mid_tx_low", 32'(tx), 32'd0);
        #2 reset_n = 1'b0;
        #1 check("async_tx_high", 32'(tx), 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.delete();
        bus_read(BASE, 1'b1, 8'h22, "status_after_rst");
        repeat (12 * CPB) @(negedge clock);
        check("tx_idle_after_rst", 32'(tx), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
